mem_initiator: RTL and testbench
================================

Name: mem_initiator

Overview:
- Requester-side controller that drives the 4-entry byte-wide memory's write/read port (wr_en, rd_en, addr, wdata, rdata).
- Accepts burst commands over a valid/ready command channel and write data over a valid/ready stream.
- Sequences single-beat memory accesses, captures read data one cycle after each rd_en, and returns responses over a valid/ready response channel.
- Used by the bench and by higher-level blocks as the sole master of the memory port.

Parameters:
- ADDR_W, 2, memory address width (depth = 2**ADDR_W = 4)
- DATA_W, 8, memory data width
- LEN_W, 2, burst length field width; beats = cmd_len+1, range 1..4

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- cmd_wr  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  LEN_W  beats minus one
- wd_valid  in  1  write data offered
- wd_ready  out  1  write data accepted
- wd_data  in  DATA_W  write beat data
- mem_wr_en  out  1  memory write enable
- mem_rd_en  out  1  memory read enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, registered by memory on the rd_en edge
- rsp_valid  out  1  response offered
- rsp_ready  in  1  response consumed
- rsp_wr  out  1  response belongs to a write burst
- rsp_data  out  DATA_W  read beat data; 0 for write responses
- rsp_last  out  1  final response of the burst
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset state: all outputs 0, FSM in IDLE, beat counter 0, address register 0.
- Reset mid-burst: the next edge returns the FSM to IDLE. No further memory enables are issued. Remaining beats and any pending response are dropped.
- FSM states: IDLE, WRITE, READ, CAPTURE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_wr, cmd_addr and cmd_len, set the beat count to cmd_len, and move to WRITE (cmd_wr=1) or READ (cmd_wr=0).
  - cmd_ready=0 in every other state.
- WRITE:
  - wd_ready=1.
  - In a cycle with wd_valid, drive mem_wr_en=1, mem_addr=current address, mem_wdata=wd_data (combinational from the current cycle). The memory writes on that edge.
  - After the last beat, move to RESP with rsp_wr=1, rsp_data=0, rsp_last=1.
  - wd_valid=0 stalls the burst with mem_wr_en=0.
- READ: drive mem_rd_en=1 and mem_addr for exactly one cycle, then move to CAPTURE.
- CAPTURE: register mem_rdata into rsp_data, set rsp_last = (beat count == 0), and move to RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_wr and rsp_last are held stable until rsp_ready.
  - On rsp_ready: write burst goes to IDLE; read with rsp_last goes to IDLE; otherwise go to READ for the next beat.
- Read latency: 3 cycles per beat from READ entry to rsp_valid (READ, CAPTURE, RESP).
- Address increments by 1 per beat modulo 2**ADDR_W (3 wraps to 0). The beat counter decrements per completed beat.
- mem_wr_en and mem_rd_en are never high in the same cycle. Both are 0 outside WRITE/READ.
- Write response is a single beat issued after all write beats are issued.
- A new cmd_valid in the same cycle that the final rsp_ready returns the FSM to IDLE is not accepted; acceptance happens in the following IDLE cycle.
- Read data after memory reset is 8'hFF per entry.

Decomposition:
- Package mem_pkg: ADDR_W/DATA_W/LEN_W defaults, state enum (IDLE, WRITE, READ, CAPTURE, RESP), and a command struct {wr, addr, len}.
- Single module. No sub-module; the FSM and datapath are small enough to stay inline.

Test Plan:
- Write single: cmd_wr=1, addr=2, len=0, wd_data=8'hA5 → one cycle with mem_wr_en=1, mem_addr=2, mem_wdata=A5; then rsp_valid, rsp_wr=1, rsp_last=1.
- Read after memory reset: read addr=1, len=0 → rsp_data=8'hFF, rsp_last=1, rsp_valid 3 cycles after acceptance.
- Write burst with wrap: addr=3, len=3, data 11,22,33,44 → mem_addr sequence 3,0,1,2. A following read burst addr=3, len=3 returns 11,22,33,44 with rsp_last only on 44.
- Backpressure: read burst len=1 with rsp_ready low for 5 cycles → rsp_data held stable, no second mem_rd_en until rsp_ready; wd_valid gaps in a write burst → mem_wr_en low during gaps.
- Reset mid-burst: assert rst during a 4-beat read after the first response → next cycle all outputs 0, busy=0, no further mem_rd_en.
- Protocol check every cycle: mem_wr_en and mem_rd_en never both 1; cmd_ready=1 only when busy=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths, FSM state encoding and the command record for mem_initiator.
package mem_pkg;

   localparam int MEM_ADDR_W = 2;
   localparam int MEM_DATA_W = 8;
   localparam int MEM_LEN_W  = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      READ    = 3'd2,
      CAPTURE = 3'd3,
      RESP    = 3'd4
   } state_e;

   // Latched burst command. After acceptance, addr tracks the current beat
   // address and len the beats still remaining (minus one).
   typedef struct packed {
      logic                  wr;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_LEN_W-1:0]  len;
   } cmd_t;

endpackage

// File: rtl/mem_initiator.sv
// Requester-side sequencer for the 4-entry byte memory port.
// Turns burst commands into single-beat memory accesses and returns one
// response per read beat, or a single response per write burst.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// WRITE   | issuing write beats as write data arrives
// READ    | one-cycle rd_en pulse for the current beat
// CAPTURE | memory read data available, registered into rsp_data
// RESP    | response offered, held until rsp_ready
module mem_initiator
   import mem_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W,
   parameter int LEN_W  = MEM_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wd_valid,
   output logic              wd_ready,
   input  logic [DATA_W-1:0] wd_data,
   output logic              mem_wr_en,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_wr,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              busy
);

   state_e            state_q, state_d;
   cmd_t              cur_q, cur_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_last_q, rsp_last_d;

   // State and datapath registers, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cur_q      <= '0;
         rsp_data_q <= '0;
         rsp_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         rsp_data_q <= rsp_data_d;
         rsp_last_q <= rsp_last_d;
      end
   end

   // Next-state and output decode. Outputs are forced low while rst is high
   // so a mid-burst reset cannot issue one more memory enable on its edge.
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      rsp_data_d = rsp_data_q;
      rsp_last_d = rsp_last_q;
      cmd_ready  = 1'b0;
      wd_ready   = 1'b0;
      mem_wr_en  = 1'b0;
      mem_rd_en  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      rsp_valid  = 1'b0;

      if (!rst) begin
         case (state_q)
            IDLE: begin
               cmd_ready = 1'b1;
               if (cmd_valid) begin
                  cur_d.wr   = cmd_wr;
                  cur_d.addr = cmd_addr;
                  cur_d.len  = cmd_len;
                  state_d    = cmd_wr ? WRITE : READ;
               end
            end
            WRITE: begin
               wd_ready = 1'b1;
               if (wd_valid) begin
                  mem_wr_en  = 1'b1;
                  mem_addr   = cur_q.addr;
                  mem_wdata  = wd_data;
                  cur_d.addr = cur_q.addr + ADDR_W'(1);
                  if (cur_q.len == '0) begin
                     rsp_data_d = '0;
                     rsp_last_d = 1'b1;
                     state_d    = RESP;
                  end else begin
                     cur_d.len = cur_q.len - LEN_W'(1);
                  end
               end
            end
            READ: begin
               mem_rd_en  = 1'b1;
               mem_addr   = cur_q.addr;
               cur_d.addr = cur_q.addr + ADDR_W'(1);
               state_d    = CAPTURE;
            end
            CAPTURE: begin
               rsp_data_d = mem_rdata;
               rsp_last_d = (cur_q.len == '0);
               state_d    = RESP;
            end
            RESP: begin
               rsp_valid = 1'b1;
               if (rsp_ready) begin
                  if (cur_q.wr || rsp_last_q) begin
                     state_d = IDLE;
                  end else begin
                     cur_d.len = cur_q.len - LEN_W'(1);
                     state_d   = READ;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign rsp_wr   = cur_q.wr;
   assign rsp_data = rsp_data_q;
   assign rsp_last = rsp_last_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a behavioural 4x8 memory model.
module tb_mem_initiator;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_wr;
   logic [1:0] cmd_addr, cmd_len;
   logic       wd_valid, wd_ready;
   logic [7:0] wd_data;
   logic       mem_wr_en, mem_rd_en;
   logic [1:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;
   logic       rsp_valid, rsp_ready, rsp_wr, rsp_last, busy;
   logic [7:0] rsp_data;

   logic       mem_init;
   logic [7:0] mem [4];

   int n_pass = 0;
   int n_chk  = 0;

   logic [7:0] wdat  [4];
   logic [1:0] waddr [4];

   always #5 clk = ~clk;

   mem_initiator dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_wr    (cmd_wr),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wd_valid  (wd_valid),
      .wd_ready  (wd_ready),
      .wd_data   (wd_data),
      .mem_wr_en (mem_wr_en),
      .mem_rd_en (mem_rd_en),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_wr    (rsp_wr),
      .rsp_data  (rsp_data),
      .rsp_last  (rsp_last),
      .busy      (busy)
   );

   // Memory model: entries reset to FF, read data registered on the rd_en edge.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 4; i++) mem[i] <= 8'hFF;
         mem_rdata <= 8'h00;
      end else begin
         if (mem_wr_en) mem[mem_addr] <= mem_wdata;
         if (mem_rd_en) mem_rdata <= mem[mem_addr];
      end
   end

   task automatic chk(input string tag, input bit ok);
      n_chk++;
      if (ok) n_pass++;
      else $error("FAIL %s", tag);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Every-cycle protocol checks.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         chk("excl_en", (mem_wr_en && mem_rd_en) === 1'b0);
         chk("rdy_busy", (cmd_ready && busy) === 1'b0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33; wdat[3] = 8'h44;
      waddr[0] = 2'd3; waddr[1] = 2'd0; waddr[2] = 2'd1; waddr[3] = 2'd2;

      rst = 1'b1; mem_init = 1'b1;
      cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
      wd_valid = 1'b0; wd_data = '0; rsp_ready = 1'b0;
      cyc();
      mem_init = 1'b0;
      cyc();
      #1;
      chk("rst_cmd_ready", cmd_ready === 1'b0);
      chk("rst_busy", busy === 1'b0);
      chk("rst_rsp_valid", rsp_valid === 1'b0);
      chk("rst_wr_en", mem_wr_en === 1'b0);
      chk("rst_rd_en", mem_rd_en === 1'b0);
      chk("rst_wd_ready", wd_ready === 1'b0);
      chk("rst_rsp_data", rsp_data === 8'h00);
      rst = 1'b0;
      #1;
      chk("idle_cmd_ready", cmd_ready === 1'b1);
      chk("idle_busy", busy === 1'b0);

      // Single write to address 2.
      cyc();
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 2'd2; cmd_len = 2'd0;
      wd_valid = 1'b1; wd_data = 8'hA5;
      #1;
      chk("w1_cmd_ready", cmd_ready === 1'b1);
      cyc();
      cmd_valid = 1'b0;
      #1;
      chk("w1_wr_en", mem_wr_en === 1'b1);
      chk("w1_addr", mem_addr === 2'd2);
      chk("w1_wdata", mem_wdata === 8'hA5);
      chk("w1_wd_ready", wd_ready === 1'b1);
      chk("w1_busy", busy === 1'b1);
      chk("w1_cmd_ready_busy", cmd_ready === 1'b0);
      cyc();
      wd_valid = 1'b0;
      #1;
      chk("w1_rsp_valid", rsp_valid === 1'b1);
      chk("w1_rsp_wr", rsp_wr === 1'b1);
      chk("w1_rsp_last", rsp_last === 1'b1);
      chk("w1_rsp_data", rsp_data === 8'h00);
      chk("w1_wr_en_off", mem_wr_en === 1'b0);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      #1;
      chk("w1_done_busy", busy === 1'b0);
      chk("w1_done_valid", rsp_valid === 1'b0);

      // Single read from an untouched entry: reset value FF, 3-cycle latency.
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 2'd1; cmd_len = 2'd0;
      cyc();
      cmd_valid = 1'b0;
      #1;
      chk("r1_rd_en", mem_rd_en === 1'b1);
      chk("r1_addr", mem_addr === 2'd1);
      chk("r1_wr_en", mem_wr_en === 1'b0);
      chk("r1_valid_c1", rsp_valid === 1'b0);
      cyc();
      chk("r1_valid_c2", rsp_valid === 1'b0);
      chk("r1_rd_en_off", mem_rd_en === 1'b0);
      cyc();
      chk("r1_valid_c3", rsp_valid === 1'b1);
      chk("r1_data", rsp_data === 8'hFF);
      chk("r1_last", rsp_last === 1'b1);
      chk("r1_rsp_wr", rsp_wr === 1'b0);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      #1;
      chk("r1_done_busy", busy === 1'b0);

      // Four-beat write wrapping 3,0,1,2 with a two-cycle data gap after beat 1.
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 2'd3; cmd_len = 2'd3;
      wd_valid = 1'b1; wd_data = wdat[0];
      cyc();
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wd_valid = 1'b1; wd_data = wdat[i];
         #1;
         chk("wb_wr_en", mem_wr_en === 1'b1);
         chk("wb_addr", mem_addr === waddr[i]);
         chk("wb_wdata", mem_wdata === wdat[i]);
         chk("wb_no_rsp", rsp_valid === 1'b0);
         cyc();
         if (i == 1) begin
            wd_valid = 1'b0;
            for (int g = 0; g < 2; g++) begin
               #1;
               chk("wb_gap_wr_en", mem_wr_en === 1'b0);
               chk("wb_gap_busy", busy === 1'b1);
               cyc();
            end
         end
      end
      wd_valid = 1'b0;
      #1;
      chk("wb_rsp_valid", rsp_valid === 1'b1);
      chk("wb_rsp_wr", rsp_wr === 1'b1);
      chk("wb_rsp_last", rsp_last === 1'b1);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;

      // Four-beat read of the same wrapped range; a new command is offered
      // alongside the final rsp_ready and must wait for the next IDLE cycle.
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 2'd3; cmd_len = 2'd3;
      cyc();
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rb_rd_en", mem_rd_en === 1'b1);
         chk("rb_addr", mem_addr === waddr[i]);
         cyc();
         chk("rb_capture_valid", rsp_valid === 1'b0);
         cyc();
         chk("rb_valid", rsp_valid === 1'b1);
         chk("rb_data", rsp_data === wdat[i]);
         chk("rb_last", rsp_last === (i == 3));
         rsp_ready = 1'b1;
         if (i == 3) begin
            cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 2'd0; cmd_len = 2'd1;
            #1;
            chk("rb_no_accept_in_resp", cmd_ready === 1'b0);
         end
         cyc();
         rsp_ready = 1'b0;
      end
      #1;
      chk("rb_idle_busy", busy === 1'b0);
      chk("rb_idle_cmd_ready", cmd_ready === 1'b1);

      // Two-beat read from address 0 with rsp_ready held low for 5 cycles.
      cyc();
      cmd_valid = 1'b0;
      #1;
      chk("bp_rd_en", mem_rd_en === 1'b1);
      chk("bp_addr", mem_addr === 2'd0);
      cyc();
      cyc();
      chk("bp_valid", rsp_valid === 1'b1);
      chk("bp_data", rsp_data === 8'h22);
      chk("bp_last", rsp_last === 1'b0);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("bp_hold_valid", rsp_valid === 1'b1);
         chk("bp_hold_data", rsp_data === 8'h22);
         chk("bp_hold_last", rsp_last === 1'b0);
         chk("bp_hold_rd_en", mem_rd_en === 1'b0);
      end
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      #1;
      chk("bp_rd2_en", mem_rd_en === 1'b1);
      chk("bp_rd2_addr", mem_addr === 2'd1);
      cyc();
      cyc();
      chk("bp2_data", rsp_data === 8'h33);
      chk("bp2_last", rsp_last === 1'b1);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      #1;
      chk("bp_done_busy", busy === 1'b0);

      // Reset asserted in the READ cycle of beat 2 of a 4-beat read.
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 2'd0; cmd_len = 2'd3;
      cyc();
      cmd_valid = 1'b0;
      cyc();
      cyc();
      chk("mr_first_data", rsp_data === 8'h22);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      #1;
      chk("mr_beat2_rd_en", mem_rd_en === 1'b1);
      rst = 1'b1;
      cyc();
      chk("mr_busy", busy === 1'b0);
      chk("mr_rsp_valid", rsp_valid === 1'b0);
      chk("mr_rd_en", mem_rd_en === 1'b0);
      chk("mr_cmd_ready", cmd_ready === 1'b0);
      chk("mr_rsp_data", rsp_data === 8'h00);
      chk("mr_rsp_last", rsp_last === 1'b0);
      chk("mr_rsp_wr", rsp_wr === 1'b0);
      chk("mr_mem_addr", mem_addr === 2'd0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("mr_after_rd_en", mem_rd_en === 1'b0);
         chk("mr_after_valid", rsp_valid === 1'b0);
         chk("mr_after_busy", busy === 1'b0);
         cyc();
      end

      // Recovery: single read of address 2, last written with 44.
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 2'd2; cmd_len = 2'd0;
      cyc();
      cmd_valid = 1'b0;
      #1;
      chk("rc_rd_addr", mem_addr === 2'd2);
      cyc();
      cyc();
      chk("rc_valid", rsp_valid === 1'b1);
      chk("rc_data", rsp_data === 8'h44);
      chk("rc_last", rsp_last === 1'b1);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      #1;
      chk("rc_done_busy", busy === 1'b0);

      cyc();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
